// File: rtl/hs4_tx_endpoint.sv
// Source side of a 4-phase req/ack crossing. Upstream words are queued in a small FIFO.
// They are then sent one at a time on o_req/o_data, with a one-cycle data setup before each request.
module hs4_tx_endpoint #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_valid,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic                        o_ready,
    output logic                        o_req,
    output logic [DATA_WIDTH-1:0]       o_data,
    input  logic                        i_ack,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_done,
    output logic                        o_timeout,
    input  logic                        i_clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [AW:0]   DEPTH  = (AW+1)'(FIFO_DEPTH);
    localparam bit            TMO_ON = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {IDLE, LOAD, REQ_HI, REQ_LO} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   push;
    logic                   pop;
    logic [TW-1:0]          phase_cnt;
    logic                   in_phase;
    logic                   phase_entry;
    logic                   to_set;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_count = wr_ptr - rd_ptr;
    assign o_ready = (o_count != DEPTH);
    assign push    = i_valid & o_ready;
    assign pop     = (state == IDLE) && (o_count != '0) && !ack_s;
    assign o_busy  = (state != IDLE) || (o_count != '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_data;
    end

    // A stale ack left high by the far side holds the FSM in IDLE until it drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop)    state_nxt = LOAD;
            LOAD:                state_nxt = REQ_HI;
            REQ_HI:  if (ack_s)  state_nxt = REQ_LO;
            REQ_LO:  if (!ack_s) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= IDLE;
            o_req  <= 1'b0;
            o_done <= 1'b0;
            o_data <= '0;
        end else begin
            state  <= state_nxt;
            o_req  <= (state_nxt == REQ_HI);
            o_done <= (state == REQ_LO) && !ack_s;
            if (pop) o_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    // The counter parks at its last value, so a waiting phase keeps re-asserting the timeout.
    assign in_phase    = (state == REQ_HI) || (state == REQ_LO);
    assign phase_entry = (state_nxt != state) && ((state_nxt == REQ_HI) || (state_nxt == REQ_LO));
    assign to_set      = TMO_ON && in_phase && (phase_cnt == T_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            phase_cnt <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (phase_entry) begin
                phase_cnt <= '0;
            end else if (in_phase && (phase_cnt != T_LAST)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if (to_set) begin
                o_timeout <= 1'b1;
            end else if (i_clr_err) begin
                o_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs4_tx_endpoint.sv
// Bench for hs4_tx_endpoint: a transaction-level model and a far-end ack responder.
// Directed scenarios add literal checks on the key timing points.
module tb_hs4_tx_endpoint;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;

    logic                      i_clk     = 1'b0;
    logic                      i_rstn    = 1'b0;
    logic                      i_valid   = 1'b0;
    logic [DW-1:0]             i_data    = '0;
    logic                      i_ack     = 1'b0;
    logic                      i_clr_err = 1'b0;
    logic                      o_ready;
    logic                      o_req;
    logic [DW-1:0]             o_data;
    logic                      o_busy;
    logic [$clog2(DEPTH):0]    o_count;
    logic                      o_done;
    logic                      o_timeout;

    int n_vec = 0;
    int n_err = 0;

    hs4_tx_endpoint #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_ready  (o_ready),
        .o_req    (o_req),
        .o_data   (o_data),
        .i_ack    (i_ack),
        .o_busy   (o_busy),
        .o_count  (o_count),
        .o_done   (o_done),
        .o_timeout(o_timeout),
        .i_clr_err(i_clr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    // Far end: echoes o_req back on i_ack after ack_delay cycles when echo_en is set.
    logic        echo_en   = 1'b0;
    int          ack_delay = 1;
    logic [15:0] req_hist  = '0;
    initial forever begin
        @(negedge i_clk);
        if (!i_rstn) req_hist = '0;
        else         req_hist = {req_hist[14:0], o_req};
        if (echo_en) i_ack = req_hist[ack_delay];
    end

    // Transaction model: pending words, the word in flight and which ack edge it awaits.
    logic [DW-1:0]   m_q[$];
    logic [DW-1:0]   m_data     = '0;
    logic [SYNC-1:0] m_sync     = '0;
    bit              m_inflight = 1'b0;
    bit              m_done     = 1'b0;
    bit              m_timeout  = 1'b0;
    int              m_stage    = 0;
    int              m_phase    = 0;

    task automatic modelStep();
        bit ack_s;
        bit acc;
        bit set_to;
        bit done_nxt;
        ack_s    = m_sync[SYNC-1];
        acc      = i_valid && (m_q.size() != DEPTH);
        set_to   = 1'b0;
        done_nxt = 1'b0;
        if (m_inflight) begin
            if (m_stage == 0) begin
                m_stage = 1;
                m_phase = 0;
            end else begin
                m_phase++;
                if (TMO != 0 && m_phase >= TMO) set_to = 1'b1;
                if (m_stage == 1 && ack_s) begin
                    m_stage = 2;
                    m_phase = 0;
                end else if (m_stage == 2 && !ack_s) begin
                    m_inflight = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
        end else if (m_q.size() != 0 && !ack_s) begin
            m_data     = m_q.pop_front();
            m_inflight = 1'b1;
            m_stage    = 0;
        end
        if (acc) m_q.push_back(i_data);
        if (set_to)         m_timeout = 1'b1;
        else if (i_clr_err) m_timeout = 1'b0;
        m_done = done_nxt;
        m_sync = {m_sync[SYNC-2:0], i_ack};
    endtask

    initial forever begin
        @(posedge i_clk or negedge i_rstn);
        if (!i_rstn) begin
            m_q.delete();
            m_data     = '0;
            m_sync     = '0;
            m_inflight = 1'b0;
            m_done     = 1'b0;
            m_timeout  = 1'b0;
            m_stage    = 0;
            m_phase    = 0;
        end else begin
            modelStep();
        end
    end

    initial forever begin
        @(negedge i_clk);
        checkOutput("req",     o_req,     32'(m_inflight && (m_stage == 1)));
        checkOutput("data",    o_data,    32'(m_data));
        checkOutput("done",    o_done,    32'(m_done));
        checkOutput("count",   o_count,   32'(m_q.size()));
        checkOutput("ready",   o_ready,   32'(m_q.size() != DEPTH));
        checkOutput("busy",    o_busy,    32'(m_inflight || (m_q.size() != 0)));
        checkOutput("timeout", o_timeout, 32'(m_timeout));
    end

    // Observed deliveries (o_data at each o_req rise) and o_done pulses.
    int            done_cnt = 0;
    logic          req_prev = 1'b0;
    logic [DW-1:0] recv_q[$];
    initial forever begin
        @(negedge i_clk);
        if (o_done === 1'b1) done_cnt++;
        if (o_req === 1'b1 && !req_prev) recv_q.push_back(o_data);
        req_prev = (o_req === 1'b1);
    end

    task automatic applyStimulus(input logic [DW-1:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick(1);
        i_valid = 1'b0;
    endtask

    task automatic waitIdle(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < max_cyc) begin
            tick(1);
            k++;
        end
        checkOutput({tag, "_idle"}, o_busy, 32'd0);
    endtask

    function automatic logic [31:0] recvAt(input int i);
        return (i < recv_q.size()) ? 32'(recv_q[i]) : 32'hFFFF_FFFF;
    endfunction

    logic [DW-1:0] burst_exp [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [DW-1:0] pp_exp    [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int d0;
        int w;
        int guard;
        bit acc;
        bit saw_full;

        tick(2);
        checkOutput("rst_req",     o_req,     32'd0);
        checkOutput("rst_data",    o_data,    32'd0);
        checkOutput("rst_count",   o_count,   32'd0);
        checkOutput("rst_ready",   o_ready,   32'd1);
        checkOutput("rst_busy",    o_busy,    32'd0);
        checkOutput("rst_timeout", o_timeout, 32'd0);
        i_rstn = 1'b1;
        tick(2);

        // Single word, ack echoes req three cycles later.
        echo_en   = 1'b1;
        ack_delay = 3;
        recv_q.delete();
        d0 = done_cnt;
        applyStimulus(8'hA5);
        tick(1);
        checkOutput("single_req_e1", o_req, 32'd0);
        tick(1);
        checkOutput("single_req_e2",  o_req,  32'd1);
        checkOutput("single_data_e2", o_data, 32'hA5);
        waitIdle(60, "single");
        checkOutput("single_done_pulses", done_cnt - d0, 32'd1);
        checkOutput("single_word", recvAt(0), 32'hA5);

        // Burst of six with i_valid held and a slow far end.
        ack_delay = 8;
        recv_q.delete();
        saw_full = 1'b0;
        w = 1;
        guard = 0;
        while (w <= 6 && guard < 400) begin
            i_valid = 1'b1;
            i_data  = DW'(w);
            acc     = o_ready;
            tick(1);
            if (o_count == 4 && o_ready == 1'b0) saw_full = 1'b1;
            if (acc) w++;
            guard++;
        end
        i_valid = 1'b0;
        checkOutput("burst_all_accepted", w, 32'd7);
        waitIdle(400, "burst");
        checkOutput("burst_full_seen", saw_full, 32'd1);
        checkOutput("burst_n", recv_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("burst_word%0d", i), recvAt(i), 32'(burst_exp[i]));

        // Stale ack holds two words; a push lands on the edge that pops the head.
        echo_en = 1'b0;
        i_ack   = 1'b1;
        recv_q.delete();
        tick(2);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("pp_pre_count", o_count, 32'd2);
        checkOutput("pp_pre_req",   o_req,   32'd0);
        i_ack = 1'b0;
        tick(2);
        i_valid = 1'b1;
        i_data  = 8'h33;
        tick(1);
        i_valid = 1'b0;
        checkOutput("pp_count", o_count, 32'd2);
        checkOutput("pp_load_data", o_data, 32'h11);
        tick(1);
        checkOutput("pp_req", o_req, 32'd1);
        echo_en   = 1'b1;
        ack_delay = 2;
        waitIdle(200, "pushpop");
        checkOutput("pp_n", recv_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("pp_word%0d", i), recvAt(i), 32'(pp_exp[i]));

        // Ack held high across reset release.
        echo_en = 1'b0;
        i_ack   = 1'b1;
        i_rstn  = 1'b0;
        tick(2);
        checkOutput("stale_rst_req",   o_req,   32'd0);
        checkOutput("stale_rst_count", o_count, 32'd0);
        i_rstn = 1'b1;
        tick(3);
        recv_q.delete();
        applyStimulus(8'h5C);
        tick(5);
        checkOutput("stale_hold_req",   o_req,   32'd0);
        checkOutput("stale_hold_count", o_count, 32'd1);
        checkOutput("stale_hold_busy",  o_busy,  32'd1);
        i_ack     = 1'b0;
        echo_en   = 1'b1;
        ack_delay = 1;
        d0 = done_cnt;
        waitIdle(60, "stale");
        checkOutput("stale_done_pulses", done_cnt - d0, 32'd1);
        checkOutput("stale_word", recvAt(0), 32'h5C);

        // Phase timeout with no ack at all.
        echo_en = 1'b0;
        i_ack   = 1'b0;
        tick(1);
        checkOutput("to_pre", o_timeout, 32'd0);
        applyStimulus(8'h77);
        tick(17);
        checkOutput("to_e17",     o_timeout, 32'd0);
        checkOutput("to_e17_req", o_req,     32'd1);
        tick(1);
        checkOutput("to_e18",     o_timeout, 32'd1);
        checkOutput("to_e18_req", o_req,     32'd1);
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        checkOutput("to_clr_while_waiting", o_timeout, 32'd1);
        tick(3);
        checkOutput("to_still_req", o_req, 32'd1);
        echo_en   = 1'b1;
        ack_delay = 0;
        waitIdle(60, "timeout");
        checkOutput("to_sticky", o_timeout, 32'd1);
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        checkOutput("to_cleared", o_timeout, 32'd0);

        // Reset while a request is up with two words queued.
        echo_en = 1'b0;
        i_ack   = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h81;
        tick(1);
        i_data  = 8'h82;
        tick(1);
        i_data  = 8'h83;
        tick(1);
        i_valid = 1'b0;
        checkOutput("mid_req",   o_req,   32'd1);
        checkOutput("mid_count", o_count, 32'd2);
        #1;
        i_rstn = 1'b0;
        #1;
        checkOutput("mid_rst_req",   o_req,   32'd0);
        checkOutput("mid_rst_count", o_count, 32'd0);
        checkOutput("mid_rst_ready", o_ready, 32'd1);
        checkOutput("mid_rst_busy",  o_busy,  32'd0);
        tick(2);
        i_rstn = 1'b1;
        tick(2);
        checkOutput("mid_post_ready", o_ready, 32'd1);
        checkOutput("mid_post_busy",  o_busy,  32'd0);

        // Normal traffic after that reset.
        echo_en   = 1'b1;
        ack_delay = 2;
        recv_q.delete();
        applyStimulus(8'h9C);
        waitIdle(60, "post");
        checkOutput("post_word", recvAt(0), 32'h9C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, got time %0t, expected under 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hs4_tx_endpoint.md
HS4_TX_ENDPOINT -- requirements
Module: hs4_tx_endpoint

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, input queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, i_ack synchronizer flops (>=2).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, max cycles per handshake phase before flagging (0 = check disabled).
REQ-005 The block SHALL have port i_clk  input  1  source-domain clock, all logic rising-edge.
REQ-006 The block SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_valid  input  1  upstream word available.
REQ-008 The block SHALL have port i_data  input  DATA_WIDTH  upstream word.
REQ-009 The block SHALL have port o_ready  output  1  queue can accept; transfer occurs on i_valid & o_ready.
REQ-010 The block SHALL have port o_req  output  1  registered 4-phase request to the far domain.
REQ-011 The block SHALL have port o_data  output  DATA_WIDTH  registered payload, stable whenever o_req=1 or ack is pending.
REQ-012 The block SHALL have port i_ack  input  1  acknowledge from far domain, asynchronous to i_clk.
REQ-013 The block SHALL have port o_busy  output  1  queue non-empty or FSM not IDLE.
REQ-014 The block SHALL have port o_count  output  clog2(FIFO_DEPTH)+1  queued entries, excluding the word in flight.
REQ-015 The block SHALL have port o_done  output  1  one-cycle pulse on handshake completion.
REQ-016 The block SHALL have port o_timeout  output  1  sticky phase-timeout flag.
REQ-017 The block SHALL have port i_clr_err  input  1  synchronous clear of o_timeout.

Function
REQ-018 i_ack SHALL pass through SYNC_STAGES flops; only the final stage (ack_s) SHALL be used by logic.
REQ-019 Queue SHALL be FIFO-ordered; o_ready = (o_count != FIFO_DEPTH); a push and a pop in the same cycle SHALL leave o_count unchanged.
REQ-020 FSM SHALL have states IDLE, LOAD, REQ_HI, REQ_LO.
REQ-021 IDLE->LOAD when queue non-empty and ack_s=0; on this edge the head SHALL be popped into o_data.
REQ-022 IDLE with queue non-empty and ack_s=1 (stale ack) SHALL remain in IDLE until ack_s=0.
REQ-023 LOAD->REQ_HI unconditionally; o_req SHALL be 1 from this edge onward (one-cycle data setup before req).
REQ-024 REQ_HI->REQ_LO when ack_s=1; o_req SHALL be 0 from this edge onward.
REQ-025 REQ_LO->IDLE when ack_s=0; o_done SHALL be 1 for exactly the following cycle.
REQ-026 o_data SHALL change only on IDLE->LOAD.
REQ-027 Latency: word pushed at edge E0 into an empty queue with FSM IDLE and ack_s=0 SHALL give o_req=1 after edge E2.
REQ-028 Phase counter SHALL clear on entry to REQ_HI and to REQ_LO and increment each cycle in those states; reaching TIMEOUT_CYC SHALL set o_timeout; the FSM SHALL keep waiting (no abort).
REQ-029 i_clr_err SHALL clear o_timeout; simultaneous set and clear SHALL leave o_timeout=1.
REQ-030 o_busy SHALL be (state != IDLE) | (o_count != 0).

Reset
REQ-031 While i_rstn=0: o_req=0, o_data=0, o_done=0, o_timeout=0, o_count=0, o_ready=1, all sync flops 0, state IDLE, queue emptied.
REQ-032 Reset mid-handshake SHALL drop o_req immediately and discard queued and in-flight words; the far endpoint SHALL be reset together with this block.

Verification
REQ-033 Single word 0xA5, ack echoes req after 3 cycles -> o_req high 2 cycles after push, o_data=0xA5 throughout, one o_done pulse, o_busy=0 afterwards.
REQ-034 Burst of 6 words 0x01..0x06 with i_valid held, slow ack -> o_ready=0 at o_count=4, all six delivered in order, no loss or duplication.
REQ-035 i_ack held 1 at reset release, one word queued -> o_req stays 0 until ack_s=0, then normal handshake.
REQ-036 TIMEOUT_CYC=16, ack never asserted -> o_timeout=1 after 16 cycles in REQ_HI, o_req held 1; i_clr_err with ack still absent -> o_timeout stays 1; i_clr_err after completion -> 0.
REQ-037 i_rstn asserted while in REQ_HI with 2 queued -> o_req=0, o_count=0 immediately; after release o_ready=1, state IDLE.
REQ-038 Push and handshake pop in the same cycle with o_count=2 -> o_count remains 2.
